// File: rtl/cscv2_pkg.sv
// -----------------------------------------------------------------------------
// cscv2_pkg -- shared definitions for the register write-back stage.
//
// Contents:
//   REG_W      data width of the register bank (4 bits)
//   DEST_W     storage width of a destination index (covers up to 16 regs)
//   wb_entry_t one queued write: {dest, data}
//   LOAD_IDLE  all-ones strobe vector (no register loading); consumers slice
//              the low NREGS bits
// -----------------------------------------------------------------------------
package cscv2_pkg;

  localparam int REG_W     = 4;
  localparam int MAX_NREGS = 16;
  localparam int DEST_W    = 4;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [REG_W-1:0]  data;
  } wb_entry_t;

  localparam logic [MAX_NREGS-1:0] LOAD_IDLE = '1;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo -- small synchronous FIFO of wb_entry_t with first-word fall-through
// read (rd_entry always shows the head entry).
//
// Parameters:
//   DEPTH  number of entries, power of two, 2..8
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset (empties the FIFO)
//   push      write wr_entry at the tail (ignored when full)
//   wr_entry  entry to enqueue
//   pop       drop the head entry (ignored when empty)
//   rd_entry  current head entry (valid when !empty)
//   count     number of stored entries, 0..DEPTH
//   full      count == DEPTH
//   empty     count == 0
// -----------------------------------------------------------------------------
module wb_fifo
  import cscv2_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                wr_entry,
  input  logic                     pop,
  output wb_entry_t                rd_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count/pointers decide
  // what is valid, and leaving the array unreset lets it map to plain RAM/regs
  // without a reset fan-out.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/reg_writeback.sv
// -----------------------------------------------------------------------------
// reg_writeback -- write-back stage in front of the 4-bit register bank.
// Accepts {dest, data} writes over valid/ready, queues them in wb_fifo and
// issues at most one write per cycle as a registered data bus plus one
// registered active-low load strobe per register.
//
// Optional feature (macro WB_HOLD_EN): adds input 'hold'; while high no entry
// is issued and the strobes stay idle, but pushes continue until full.
//
// Parameters:
//   NREGS  number of destination registers, 2..16
//   DEPTH  FIFO entries, power of two, 2..8
//   IDXW   destination index width, derived from NREGS
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   in_valid  upstream offers a write
//   in_ready  block can accept (FIFO not full)
//   in_dest   destination register index
//   in_data   value to write
//   hold      (WB_HOLD_EN only) stall issue
//   load_n    registered active-low load strobes, at most one bit low
//   wdata     registered data bus to all registers
//   busy      entries queued or a write is being presented
// -----------------------------------------------------------------------------
module reg_writeback
  import cscv2_pkg::*;
#(
  parameter  int NREGS = 4,
  parameter  int DEPTH = 2,
  localparam int IDXW  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDXW-1:0]   in_dest,
  input  logic [REG_W-1:0]  in_data,
`ifdef WB_HOLD_EN
  input  logic              hold,
`endif
  output logic [NREGS-1:0]  load_n,
  output logic [REG_W-1:0]  wdata,
  output logic              busy
);

  localparam logic [NREGS-1:0] IDLE = LOAD_IDLE[NREGS-1:0];

  wb_entry_t                 wr_entry;
  wb_entry_t                 head;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      hold_active;
  logic [NREGS-1:0]          strobe;

`ifdef WB_HOLD_EN
  assign hold_active = hold;
`else
  assign hold_active = 1'b0;
`endif

  // No look-ahead at a same-cycle pop: a full FIFO refuses even while popping.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  // The head is issued on the edge after it was pushed, never the same edge.
  assign pop      = !fifo_empty && !hold_active;

  assign wr_entry.dest = DEST_W'(in_dest);
  assign wr_entry.data = in_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .rd_entry (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Out-of-range destinations (non-power-of-two NREGS) match no bit, so the
  // entry retires with all strobes idle.
  // NOTE: strobe gets its default before the loop so every path assigns it;
  // otherwise synthesis would infer a latch.
  always_comb begin
    strobe = IDLE;
    for (int i = 0; i < NREGS; i++) begin
      if (head.dest == DEST_W'(i)) strobe[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_n <= IDLE;
      wdata  <= '0;
    end else if (pop) begin
      load_n <= strobe;
      wdata  <= head.data;
    end else begin
      load_n <= IDLE;
    end
  end

  assign busy = (fifo_count != '0) || (load_n != IDLE);

endmodule
